data_mem_responder: RTL
=======================

# data_mem_responder

Multi-cycle data-memory responder serving the pipeline's memory stage: it accepts one load or store request at a time, holds the requester with a stall signal for a fixed number of wait cycles, then commits the store or returns the load word. It sits between the memory stage (the initiator) and the word-addressed data storage. It replaces the zero-wait combinational RAM path with a timed, stall-based handshake.

## Interface
- ADDR_WIDTH, 7: word-address width; storage depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width.
- LATENCY, 2: stall cycles per request, including the request cycle; legal range 1..15.

- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_read  input  1  load request; held stable by the requester while stall is high.
- req_write  input  1  store request; held stable while stall is high.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  store data.
- stall  output  1  requester must hold its request and inputs; combinational.
- resp_valid  output  1  completion cycle for the current request; registered.
- resp_rdata  output  DATA_WIDTH  load data; registered and held until the next load completes.

## Operation
- FSM states:
  - IDLE: no request in progress.
  - BUSY: wait cycles counting down in a 4-bit counter cnt.
  - DONE: the single completion cycle.
- Request present means req_read or req_write is high.
- stall = (IDLE and request present) or BUSY. stall is low in DONE, and in IDLE when no request is present.
- IDLE with a request present:
  - the block latches the op (read or write), address, and wdata;
  - if LATENCY == 1, the next state is DONE;
  - otherwise the next state is BUSY with cnt = LATENCY-2.
- BUSY: if cnt == 0, the next state is DONE; otherwise cnt decrements.
- Commit happens at the edge entering DONE:
  - a store writes the latched wdata to the latched address;
  - a load registers the array word into resp_rdata.
- DONE: resp_valid = 1. The next state is always IDLE, regardless of inputs, so each request is served exactly once.
- If req_read and req_write are both high, the request is treated as a store: the array is written and resp_rdata is unchanged.
- Addresses use ADDR_WIDTH bits only; there is no out-of-range condition.
- Storage contents are not reset.

## Timing
- A request presented in cycle 0 produces:
  - stall high in cycles 0..LATENCY-1;
  - resp_valid high in cycle LATENCY;
  - resp_rdata valid from cycle LATENCY.
- The requester advances at the edge ending cycle LATENCY. Its next request seen in IDLE starts at cycle LATENCY+1.
- Throughput: one request per LATENCY+1 cycles.
- Read-after-write to the same address in back-to-back requests returns the new data, because the store commits before the next request is accepted.
- Reset values: state = IDLE, cnt = 0, resp_valid = 0, resp_rdata = 0. stall is therefore 0 unless a request is present.
- Reset asserted in IDLE or BUSY: the request is aborted, no array write occurs, and the requester must re-present it.
- Reset asserted in DONE: an already-committed store is retained.

## Structure
- Shared package holds:
  - the FSM state enum: IDLE, BUSY, DONE;
  - LATENCY_MIN = 1 and LATENCY_MAX = 15;
  - the cnt width constant (4).
- One sub-module, data_mem_array:
  - single-port, synchronous write, synchronous read;
  - ports: clock, we, re, addr, wdata, rdata;
  - no reset.
- The FSM, latches, counter and output registers live in data_mem_responder.

## Test plan
- After reset, hold req_read = req_write = 0 for 5 cycles → stall = 0, resp_valid = 0, resp_rdata = 0 throughout.
- With LATENCY = 2: store 0xDEADBEEF to address 0x05, then load from 0x05 → each request stalls exactly 2 cycles and completes with one resp_valid pulse; the load returns resp_rdata = 0xDEADBEEF.
- With LATENCY = 1: load address 0x7F after storing 0x12345678 there → stall lasts 1 cycle; resp_valid follows in the next cycle with 0x12345678.
- Assert req_read and req_write together with addr 0x10 and wdata 0xA5A5A5A5 → behaves as a store; resp_rdata keeps its prior value; a subsequent load of 0x10 returns 0xA5A5A5A5.
- Assert reset during the BUSY cycle of a store of 0x11111111 to address 0x20, which previously held 0x22222222 → outputs return to reset values; a later load of 0x20 returns 0x22222222.
- With LATENCY = 4: hold a load request continuously for 12 cycles → stall is high for 4 cycles, low for 1 cycle (resp_valid), and the pattern repeats; exactly 2 completed responses.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package data_mem_responder_pkg;

    // Legal range of the per-request stall latency.
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    // Width of the wait-cycle down-counter; wide enough for LATENCY_MAX-2.
    localparam int CNT_WIDTH = 4;

    // Responder FSM: waiting for a request, counting wait cycles, completing.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter preload for a request: the BUSY state spends cnt+1 cycles,
    // and the IDLE request cycle accounts for one more stall cycle.
    function automatic logic [CNT_WIDTH-1:0] cnt_preload(input int latency);
        int v;
        v = (latency > 1) ? (latency - 2) : 0;
        return v[CNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed single-port storage with synchronous write and
// synchronous, enabled read. The read register holds its value between reads.
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Store on we, capture the addressed word into rdata on re.
    // NOTE: the storage has no reset; resetting a RAM array forbids mapping it
    // onto block memory and its contents are defined by writes, not by reset.
    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Stall-based responder between the memory stage and the data storage.
// One request at a time: stall for LATENCY cycles, commit at the edge into
// DONE, then pulse resp_valid for one cycle. LATENCY must lie in 1..15.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata
);

    localparam logic [CNT_WIDTH-1:0] CNT_INIT = cnt_preload(LATENCY);

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_next;

    // Request captured in IDLE; a simultaneous read+write is a store.
    logic                  r_op_write;
    logic                  r_op_read;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  r_resp_valid;
    logic                  r_rdata_loaded;

    logic                  w_req;
    logic                  w_accept;
    logic                  w_stall;
    logic                  w_commit;
    logic                  w_op_write;
    logic                  w_op_read;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_wdata;
    logic                  w_we;
    logic                  w_re;
    logic [DATA_WIDTH-1:0] w_arr_rdata;

    assign w_req = req_read | req_write;

    // Next-state, counter and array-access decode for the responder FSM.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        w_op_write   = r_op_write;
        w_op_read    = r_op_read;
        w_acc_addr   = r_addr;
        w_acc_wdata  = r_wdata;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_stall     = 1'b1;
                    w_accept    = 1'b1;
                    // With LATENCY == 1 the commit happens at the end of the
                    // request cycle, so the live inputs drive the array.
                    w_op_write  = req_write;
                    w_op_read   = req_read & ~req_write;
                    w_acc_addr  = req_addr;
                    w_acc_wdata = req_wdata;
                    if (LATENCY == 1) begin
                        w_state_next = ST_DONE;
                        w_commit     = 1'b1;
                    end else begin
                        w_state_next = ST_BUSY;
                        w_cnt_next   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == '0) begin
                    w_state_next = ST_DONE;
                    w_commit     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                // Always back to IDLE so a held request is served once.
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_we = w_commit & w_op_write;
    assign w_re = w_commit & w_op_read;

    // FSM state, counter, op flags and response registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_op_write     <= 1'b0;
            r_op_read      <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_rdata_loaded <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_resp_valid <= (w_state_next == ST_DONE);
            if (w_accept) begin
                r_op_write <= req_write;
                r_op_read  <= req_read & ~req_write;
            end
            if (w_re) begin
                r_rdata_loaded <= 1'b1;
            end
        end
    end

    // Address and store data captured with the request; pure datapath.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    data_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clock (clock),
        .we    (w_we),
        .re    (w_re),
        .addr  (w_acc_addr),
        .wdata (w_acc_wdata),
        .rdata (w_arr_rdata)
    );

    // The array read register only changes on a load commit, so it already
    // holds the last load word; r_rdata_loaded supplies the zero reset value.
    assign resp_rdata = r_rdata_loaded ? w_arr_rdata : '0;
    assign resp_valid = r_resp_valid;
    assign stall      = w_stall;

endmodule
